// File: rtl/omsp_sha512_hash_reader_if.sv
// Bus between the SHA-512 hash reader and its surroundings: padder read port,
// halfword readout port and expected-digest compare stream.
interface omsp_sha512_hash_reader_if;
    logic        start;
    logic        abort;
    logic        pad_busy;
    logic [1:0]  pad_cmd;
    logic [31:0] pad_hash;
    logic [4:0]  rd_addr;
    logic [15:0] rd_data;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic        busy;
    logic        hash_valid;
    logic        done;
    logic        cmp_done;
    logic        match;

    modport slave (
        input  start, abort, pad_busy, pad_hash, rd_addr, exp_valid, exp_data,
        output pad_cmd, rd_data, busy, hash_valid, done, cmp_done, match
    );

    modport master (
        output start, abort, pad_busy, pad_hash, rd_addr, exp_valid, exp_data,
        input  pad_cmd, rd_data, busy, hash_valid, done, cmp_done, match
    );
endinterface

// File: rtl/omsp_sha512_hash_reader.sv
// Reads the 512-bit digest out of the SHA-512 padder into a local buffer,
// serves it as 16-bit halfwords and optionally compares it to an expected value.
module omsp_sha512_hash_reader #(
    parameter int READ_LATENCY = 3,
    parameter int CMP_WORDS    = 32
) (
    input  logic clk,
    input  logic rst,
    omsp_sha512_hash_reader_if.slave bus
);
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_BUSY, S_CMD, S_LAT, S_CAPTURE, S_READY
    } state_t;

    state_t            r_state;
    logic [15:0][31:0] r_words;
    logic [LAT_W-1:0]  r_lat_cnt;
    logic [3:0]        r_widx;
    logic [5:0]        r_cidx;
    logic              r_mismatch;
    logic [1:0]        r_pad_cmd;
    logic [15:0]       r_rd_data;
    logic              r_busy;
    logic              r_hash_valid;
    logic              r_done;
    logic              r_cmp_done;
    logic              r_match;

    logic [15:0]       w_rd_hw;
    logic [15:0]       w_cmp_hw;
    logic              w_neq;

    // Word k holds H(k); its upper half is the even halfword.
    always_comb begin
        w_rd_hw  = bus.rd_addr[0] ? r_words[bus.rd_addr[4:1]][15:0]
                                  : r_words[bus.rd_addr[4:1]][31:16];
        w_cmp_hw = r_cidx[0] ? r_words[r_cidx[4:1]][15:0]
                             : r_words[r_cidx[4:1]][31:16];
        w_neq    = (bus.exp_data != w_cmp_hw);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_words      <= '0;
            r_lat_cnt    <= '0;
            r_widx       <= '0;
            r_cidx       <= '0;
            r_mismatch   <= 1'b0;
            r_pad_cmd    <= 2'b00;
            r_rd_data    <= '0;
            r_busy       <= 1'b0;
            r_hash_valid <= 1'b0;
            r_done       <= 1'b0;
            r_cmp_done   <= 1'b0;
            r_match      <= 1'b0;
        end else begin
            r_rd_data <= w_rd_hw;
            r_done    <= 1'b0;
            r_pad_cmd <= 2'b00;
            if (bus.abort) begin
                // Buffer is deliberately kept; only status is dropped.
                r_state      <= S_IDLE;
                r_busy       <= 1'b0;
                r_hash_valid <= 1'b0;
                r_cmp_done   <= 1'b0;
                r_match      <= 1'b0;
                r_mismatch   <= 1'b0;
                r_cidx       <= '0;
            end else begin
                case (r_state)
                    S_IDLE, S_READY: begin
                        if (bus.start) begin
                            r_state      <= S_WAIT_BUSY;
                            r_busy       <= 1'b1;
                            r_words      <= '0;
                            r_hash_valid <= 1'b0;
                            r_cmp_done   <= 1'b0;
                            r_match      <= 1'b0;
                            r_mismatch   <= 1'b0;
                            r_lat_cnt    <= '0;
                            r_widx       <= '0;
                            r_cidx       <= '0;
                        end else if (r_state == S_READY && !r_cmp_done && bus.exp_valid) begin
                            r_mismatch <= r_mismatch | w_neq;
                            r_cidx     <= r_cidx + 6'd1;
                            if (r_cidx == 6'(CMP_WORDS - 1)) begin
                                r_cmp_done <= 1'b1;
                                r_match    <= !(r_mismatch | w_neq);
                            end
                        end
                    end
                    S_WAIT_BUSY: begin
                        if (!bus.pad_busy) begin
                            r_state   <= S_CMD;
                            r_pad_cmd <= 2'b01;
                        end
                    end
                    S_CMD: begin
                        r_state   <= S_LAT;
                        r_lat_cnt <= '0;
                    end
                    S_LAT: begin
                        if (r_lat_cnt == LAT_W'(READ_LATENCY - 1)) begin
                            r_state <= S_CAPTURE;
                            r_widx  <= '0;
                        end else begin
                            r_lat_cnt <= r_lat_cnt + 1'b1;
                        end
                    end
                    S_CAPTURE: begin
                        r_words[r_widx] <= bus.pad_hash;
                        r_widx          <= r_widx + 4'd1;
                        if (r_widx == 4'd15) begin
                            r_state      <= S_READY;
                            r_busy       <= 1'b0;
                            r_hash_valid <= 1'b1;
                            r_done       <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.pad_cmd    = r_pad_cmd;
    assign bus.rd_data    = r_rd_data;
    assign bus.busy       = r_busy;
    assign bus.hash_valid = r_hash_valid;
    assign bus.done       = r_done;
    assign bus.cmp_done   = r_cmp_done;
    assign bus.match      = r_match;
endmodule

// File: tb/tb_omsp_sha512_hash_reader.sv
// Directed bench for omsp_sha512_hash_reader with a small padder model that
// answers the read command with base+i on capture cycle i.
module tb_omsp_sha512_hash_reader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    omsp_sha512_hash_reader_if bus();

    omsp_sha512_hash_reader #(.READ_LATENCY(3), .CMP_WORDS(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          n_chk = 0;
    int          n_bad = 0;
    int          n_cmd = 0;
    int          k     = 100;
    logic [31:0] base  = 32'h0;

    // Padder: hash word i is presented in the 4th..19th cycle after the cmd cycle.
    always @(negedge clk) begin
        if (bus.pad_cmd == 2'b01) begin
            k = 0;
            n_cmd++;
        end else if (k < 100) begin
            k++;
        end
        bus.pad_hash = (k >= 4 && k < 20) ? base + 32'(k - 4) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] hw_exp(input logic [31:0] b, input int h);
        logic [31:0] w;
        w = b + 32'(h / 2);
        return (h % 2 == 1) ? w[15:0] : w[31:16];
    endfunction

    task automatic rd(input string tag, input logic [4:0] a, input logic [15:0] exp);
        bus.rd_addr = a;
        step(1);
        chk(tag, bus.rd_data, exp);
    endtask

    task automatic wait_valid(input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            step(1);
            if (bus.hash_valid) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic cmp_run(input int bad);
        for (int h = 0; h < 32; h++) begin
            bus.exp_valid = 1'b1;
            bus.exp_data  = hw_exp(base, h) ^ ((h == bad) ? 16'h0100 : 16'h0000);
            step(1);
            bus.exp_valid = 1'b0;
            bus.exp_data  = 16'h0;
            if (h % 4 == 1) step(2);
            if (h == 30) chk("cmp_not_yet", bus.cmp_done, 0);
        end
    endtask

    int cyc;
    int cmd0;

    initial begin
        rst = 1'b1;
        bus.start = 0; bus.abort = 0; bus.pad_busy = 0;
        bus.rd_addr = 0; bus.exp_valid = 0; bus.exp_data = 0;
        step(3);
        chk("rst_cmd", bus.pad_cmd, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_hv", bus.hash_valid, 0);
        chk("rst_outs", {bus.done, bus.cmp_done, bus.match, bus.rd_data}, 0);
        rst = 1'b0;
        step(1);

        // Nominal read, padder busy for 10 cycles
        base = 32'h1000_0000;
        cmd0 = n_cmd;
        bus.pad_busy = 1; bus.start = 1;
        step(1);
        bus.start = 0;
        chk("nom_busy", bus.busy, 1);
        step(9);
        chk("nom_cmd_pre", bus.pad_cmd, 2'b00);
        bus.pad_busy = 0;
        step(1);
        chk("nom_cmd_on", bus.pad_cmd, 2'b01);
        step(1);
        chk("nom_cmd_off", bus.pad_cmd, 2'b00);
        wait_valid(40, cyc);
        chk("nom_lat", cyc, 19);
        chk("nom_done", bus.done, 1);
        chk("nom_idle", bus.busy, 0);
        step(1);
        chk("nom_done_pulse", bus.done, 0);
        chk("nom_cmd_count", n_cmd - cmd0, 1);
        rd("nom_hw0", 5'd0, 16'h1000);
        rd("nom_hw1", 5'd1, 16'h0000);
        rd("nom_hw5", 5'd5, 16'h0002);
        rd("nom_hw30", 5'd30, 16'h1000);
        rd("nom_hw31", 5'd31, 16'h000F);

        // Compare pass
        cmp_run(-1);
        chk("pass_done", bus.cmp_done, 1);
        chk("pass_match", bus.match, 1);

        // Restart from READY with padder idle: clears status, 21-cycle read
        base = 32'h1234_5670;
        bus.start = 1;
        step(1);
        bus.start = 0;
        chk("rs_cmp_clr", bus.cmp_done, 0);
        chk("rs_match_clr", bus.match, 0);
        chk("rs_hv_clr", bus.hash_valid, 0);
        wait_valid(40, cyc);
        chk("imm_lat", cyc, 21);
        rd("imm_hw3", 5'd3, 16'h5671);

        // Compare fail on halfword 17, then extra exp_valid is ignored
        cmp_run(17);
        chk("fail_done", bus.cmp_done, 1);
        chk("fail_match", bus.match, 0);
        bus.exp_valid = 1; bus.exp_data = hw_exp(base, 0);
        step(2);
        bus.exp_valid = 0;
        chk("extra_done", bus.cmp_done, 1);
        chk("extra_match", bus.match, 0);

        // Abort while capturing word 7
        base = 32'h2000_0000;
        bus.start = 1;
        step(1);
        bus.start = 0;
        step(12);
        bus.abort = 1;
        step(1);
        bus.abort = 0;
        chk("ab_cmd", bus.pad_cmd, 0);
        chk("ab_hv", bus.hash_valid, 0);
        chk("ab_busy", bus.busy, 0);
        chk("ab_cmp", {bus.cmp_done, bus.match}, 0);
        rd("ab_hw12", 5'd12, 16'h2000);
        rd("ab_hw13", 5'd13, 16'h0006);
        rd("ab_hw14", 5'd14, 16'h0000);
        chk("ab_still_idle", bus.busy, 0);

        // start together with abort stays idle
        bus.start = 1; bus.abort = 1;
        step(1);
        bus.start = 0; bus.abort = 0;
        step(2);
        chk("sa_busy", bus.busy, 0);
        chk("sa_cmd", bus.pad_cmd, 0);

        // Fresh full read after abort
        base = 32'h3000_0000;
        cmd0 = n_cmd;
        bus.pad_busy = 1; bus.start = 1;
        step(1);
        bus.start = 0;
        step(1);
        bus.pad_busy = 0;
        wait_valid(60, cyc);
        chk("re_valid", bus.hash_valid, 1);
        chk("re_cmd_count", n_cmd - cmd0, 1);
        rd("re_hw14", 5'd14, 16'h3000);
        rd("re_hw15", 5'd15, 16'h0007);
        rd("re_hw31", 5'd31, 16'h000F);

        // start ignored in WAIT_BUSY, then reset during LAT
        cmp_run(-1);
        chk("pre_rst_match", bus.match, 1);
        bus.pad_busy = 1; bus.start = 1;
        step(1);
        bus.start = 0;
        step(2);
        bus.start = 1;
        step(1);
        bus.start = 0;
        chk("wb_busy", bus.busy, 1);
        chk("wb_cmd", bus.pad_cmd, 0);
        bus.pad_busy = 0;
        step(1);
        chk("wb_cmd_on", bus.pad_cmd, 2'b01);
        step(2);
        rst = 1;
        step(1);
        rst = 0;
        chk("mr_cmd", bus.pad_cmd, 0);
        chk("mr_busy", bus.busy, 0);
        chk("mr_outs", {bus.hash_valid, bus.done, bus.cmp_done, bus.match, bus.rd_data}, 0);
        step(8);
        chk("mr_stay_idle", bus.busy, 0);
        rd("mr_buf_clr", 5'd31, 16'h0000);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
